// File: rtl/card_draw_scheduler_if.sv
// Card draw bus: requests and round clear from the round FSM, rank from the
// LUT, and grant/card/hand status back to the round FSM and display logic.
interface card_draw_scheduler_if;
  logic       clr_round;
  logic       req_player;
  logic       req_house;
  logic       lut_pip;
  logic [3:0] lut_number;
  logic       grant_player;
  logic       grant_house;
  logic       card_valid;
  logic       card_owner;
  logic [3:0] card_num;
  logic [2:0] player_cnt;
  logic [2:0] house_cnt;
  logic [6:0] player_pts;
  logic [6:0] house_pts;
  logic       player_bust;
  logic       house_bust;
  logic       player_five;
  logic       house_five;
  logic       busy;
  logic       rank_err;

  // Round FSM / LUT side
  modport master (
    output clr_round, req_player, req_house, lut_number,
    input  lut_pip, grant_player, grant_house, card_valid, card_owner, card_num,
           player_cnt, house_cnt, player_pts, house_pts, player_bust, house_bust,
           player_five, house_five, busy, rank_err
  );

  // Scheduler side
  modport slave (
    input  clr_round, req_player, req_house, lut_number,
    output lut_pip, grant_player, grant_house, card_valid, card_owner, card_num,
           player_cnt, house_cnt, player_pts, house_pts, player_bust, house_bust,
           player_five, house_five, busy, rank_err
  );
endinterface

// File: rtl/card_draw_scheduler.sv
// Card draw scheduler for ten-and-a-half: arbitrates player/house draw
// requests onto the shared card LUT and keeps per-hand count, half-point
// total and bust/five-card flags. All outputs come straight from flops.
module card_draw_scheduler #(
  parameter int unsigned LUT_LAT    = 2,
  parameter int unsigned MAX_CARDS  = 5,
  parameter int unsigned BUST_LIMIT = 21
) (
  input  logic                  clk,
  input  logic                  rst_n,
  card_draw_scheduler_if.slave  bus
);

  localparam int unsigned WW = (LUT_LAT > 1) ? $clog2(LUT_LAT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(LUT_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          rr_q, rr_d;        // 1: house wins the next tie
  logic          owner_q, owner_d;  // side of the draw in flight

  logic       pip_q, pip_d;
  logic       gp_q, gp_d;
  logic       gh_q, gh_d;
  logic       cv_q, cv_d;
  logic       co_q, co_d;
  logic [3:0] cn_q, cn_d;
  logic [2:0] pc_q, pc_d;
  logic [2:0] hc_q, hc_d;
  logic [6:0] pp_q, pp_d;
  logic [6:0] hp_q, hp_d;
  logic       pb_q, pb_d;
  logic       hb_q, hb_d;
  logic       pf_q, pf_d;
  logic       hf_q, hf_d;
  logic       busy_q, busy_d;
  logic       rerr_q, rerr_d;

  logic       elig_p, elig_h, win_h;
  logic       bad_rank;
  logic [6:0] val, sum;
  logic [2:0] new_cnt;
  logic       new_bust, new_five;

  function automatic logic [6:0] card_value(input logic [3:0] r);
    logic [6:0] v;
    v = '0;
    if (r >= 4'd1 && r <= 4'd10) v = {2'b00, r, 1'b0};
    else if (r >= 4'd11 && r <= 4'd13) v = 7'd1;
    return v;
  endfunction

  // Eligibility and the owner-side result of the card currently on the LUT
  always_comb begin
    elig_p   = bus.req_player & ~pb_q & (pc_q < 3'(MAX_CARDS));
    elig_h   = bus.req_house  & ~hb_q & (hc_q < 3'(MAX_CARDS));
    win_h    = elig_h & (~elig_p | rr_q);
    bad_rank = (bus.lut_number == 4'd0) || (bus.lut_number > 4'd13);
    val      = card_value(bus.lut_number);
    sum      = (owner_q ? hp_q : pp_q) + val;
    new_cnt  = (owner_q ? hc_q : pc_q) + 3'd1;
    new_bust = (owner_q ? hb_q : pb_q) | (sum > 7'(BUST_LIMIT));
    new_five = (owner_q ? hf_q : pf_q) | ((new_cnt == 3'(MAX_CARDS)) & ~new_bust);
  end

  // Next-state and next-output logic; clr_round overrides everything
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    pip_d   = 1'b0;
    gp_d    = 1'b0;
    gh_d    = 1'b0;
    cv_d    = 1'b0;
    co_d    = co_q;
    cn_d    = cn_q;
    pc_d    = pc_q;
    hc_d    = hc_q;
    pp_d    = pp_q;
    hp_d    = hp_q;
    pb_d    = pb_q;
    hb_d    = hb_q;
    pf_d    = pf_q;
    hf_d    = hf_q;
    rerr_d  = rerr_q;

    if (bus.clr_round) begin
      state_d = IDLE;
      wait_d  = '0;
      pc_d    = '0;
      hc_d    = '0;
      pp_d    = '0;
      hp_d    = '0;
      pb_d    = 1'b0;
      hb_d    = 1'b0;
      pf_d    = 1'b0;
      hf_d    = 1'b0;
      rerr_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (elig_p | elig_h) begin
            state_d = ISSUE;
            pip_d   = 1'b1;
            gp_d    = ~win_h;
            gh_d    = win_h;
            owner_d = win_h;
            rr_d    = ~win_h;
          end
        end
        ISSUE: begin
          state_d = WAIT;
          wait_d  = '0;
        end
        WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_d = IDLE;
            cv_d    = 1'b1;
            co_d    = owner_q;
            cn_d    = bus.lut_number;
            if (bad_rank) rerr_d = 1'b1;
            if (owner_q) begin
              hc_d = new_cnt;
              hp_d = sum;
              hb_d = new_bust;
              hf_d = new_five;
            end else begin
              pc_d = new_cnt;
              pp_d = sum;
              pb_d = new_bust;
              pf_d = new_five;
            end
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; asynchronous reset clears everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      pip_q   <= 1'b0;
      gp_q    <= 1'b0;
      gh_q    <= 1'b0;
      cv_q    <= 1'b0;
      co_q    <= 1'b0;
      cn_q    <= '0;
      pc_q    <= '0;
      hc_q    <= '0;
      pp_q    <= '0;
      hp_q    <= '0;
      pb_q    <= 1'b0;
      hb_q    <= 1'b0;
      pf_q    <= 1'b0;
      hf_q    <= 1'b0;
      busy_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      pip_q   <= pip_d;
      gp_q    <= gp_d;
      gh_q    <= gh_d;
      cv_q    <= cv_d;
      co_q    <= co_d;
      cn_q    <= cn_d;
      pc_q    <= pc_d;
      hc_q    <= hc_d;
      pp_q    <= pp_d;
      hp_q    <= hp_d;
      pb_q    <= pb_d;
      hb_q    <= hb_d;
      pf_q    <= pf_d;
      hf_q    <= hf_d;
      busy_q  <= busy_d;
      rerr_q  <= rerr_d;
    end
  end

  // Output drive
  always_comb begin
    bus.lut_pip      = pip_q;
    bus.grant_player = gp_q;
    bus.grant_house  = gh_q;
    bus.card_valid   = cv_q;
    bus.card_owner   = co_q;
    bus.card_num     = cn_q;
    bus.player_cnt   = pc_q;
    bus.house_cnt    = hc_q;
    bus.player_pts   = pp_q;
    bus.house_pts    = hp_q;
    bus.player_bust  = pb_q;
    bus.house_bust   = hb_q;
    bus.player_five  = pf_q;
    bus.house_five   = hf_q;
    bus.busy         = busy_q;
    bus.rank_err     = rerr_q;
  end

endmodule

// File: tb/tb_card_draw_scheduler.sv
// Directed bench for card_draw_scheduler (LUT_LAT=2, MAX_CARDS=5, BUST_LIMIT=21).
module tb_card_draw_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  card_draw_scheduler_if bus ();

  card_draw_scheduler #(
    .LUT_LAT    (2),
    .MAX_CARDS  (5),
    .BUST_LIMIT (21)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request from one side; checks grant and card_valid latency.
  task automatic do_draw(input logic house, input logic [3:0] num);
    int k;
    @(negedge clk);
    bus.lut_number = num;
    if (house) bus.req_house = 1'b1; else bus.req_player = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!(bus.grant_player || bus.grant_house) && k < 10);
    bus.req_player = 1'b0;
    bus.req_house  = 1'b0;
    chk("grant_lat", k, 1);
    chk("grant_side", {bus.grant_house, bus.grant_player}, house ? 2'b10 : 2'b01);
    chk("pip_with_grant", bus.lut_pip, 1);
    k = 0;
    do begin @(negedge clk); k++; end
    while (!bus.card_valid && k < 10);
    chk("cv_lat", k, 3);
    chk("cv_owner", bus.card_owner, house);
    chk("cv_num", bus.card_num, num);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    bus.clr_round = 1'b1;
    @(negedge clk);
    bus.clr_round = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, c, cnt_g, cnt_v;
    logic [3:0] seq;
    logic dual;

    bus.clr_round  = 1'b0;
    bus.req_player = 1'b0;
    bus.req_house  = 1'b0;
    bus.lut_number = 4'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_pip", bus.lut_pip, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cv", bus.card_valid, 0);
    chk("rst_pcnt", bus.player_cnt, 0);
    chk("rst_hpts", bus.house_pts, 0);
    rst_n = 1'b1;

    // 1: single player draw of 7
    do_draw(1'b0, 4'd7);
    chk("t1_pts", bus.player_pts, 14);
    chk("t1_cnt", bus.player_cnt, 1);
    chk("t1_hcnt", bus.house_cnt, 0);
    @(negedge clk);
    chk("t1_cv_drop", bus.card_valid, 0);
    chk("t1_idle", bus.busy, 0);

    // 2: 10 then 1 busts the player (22 > 21); further requests masked
    clr_pulse();
    chk("t2_clr_pts", bus.player_pts, 0);
    do_draw(1'b0, 4'd10);
    chk("t2_pts20", bus.player_pts, 20);
    chk("t2_nobust20", bus.player_bust, 0);
    do_draw(1'b0, 4'd1);
    chk("t2_pts22", bus.player_pts, 22);
    chk("t2_bust", bus.player_bust, 1);
    chk("t2_cnt", bus.player_cnt, 2);
    chk("t2_five", bus.player_five, 0);
    bus.req_player = 1'b1;
    cnt_g = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.grant_player || bus.lut_pip) cnt_g++;
    end
    bus.req_player = 1'b0;
    chk("t2_masked", cnt_g, 0);

    // Reset pulse: restores round-robin to player and clears hands
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_bust", bus.player_bust, 0);
    chk("rst2_pts", bus.player_pts, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3: both requests held, four draws alternate P,H,P,H
    @(negedge clk);
    bus.lut_number = 4'd3;
    bus.req_player = 1'b1;
    bus.req_house  = 1'b1;
    g = 0;
    seq = '0;
    dual = 1'b0;
    for (c = 0; c < 40 && g < 4; c++) begin
      @(negedge clk);
      if (bus.grant_player || bus.grant_house) begin
        seq[g] = bus.grant_house;
        dual = dual | (bus.grant_player & bus.grant_house);
        g++;
      end
    end
    bus.req_player = 1'b0;
    bus.req_house  = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end
    while (!bus.card_valid && c < 10);
    chk("t3_grants", g, 4);
    chk("t3_seq", seq, 4'b1010);
    chk("t3_dual", dual, 0);
    chk("t3_last_cv", c, 3);
    chk("t3_pcnt", bus.player_cnt, 2);
    chk("t3_hcnt", bus.house_cnt, 2);
    chk("t3_ppts", bus.player_pts, 12);
    chk("t3_hpts", bus.house_pts, 12);

    // 4: house 1,1,1,12,13 -> 8 points, five-card hand, then locked
    clr_pulse();
    do_draw(1'b1, 4'd1);
    do_draw(1'b1, 4'd1);
    do_draw(1'b1, 4'd1);
    do_draw(1'b1, 4'd12);
    chk("t4_five_at4", bus.house_five, 0);
    chk("t4_pts_at4", bus.house_pts, 7);
    do_draw(1'b1, 4'd13);
    chk("t4_hcnt", bus.house_cnt, 5);
    chk("t4_hpts", bus.house_pts, 8);
    chk("t4_five", bus.house_five, 1);
    chk("t4_bust", bus.house_bust, 0);
    bus.req_house = 1'b1;
    cnt_g = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.grant_house || bus.lut_pip) cnt_g++;
    end
    bus.req_house = 1'b0;
    chk("t4_masked", cnt_g, 0);

    // 5: clr_round during WAIT discards the card and clears the hands
    @(negedge clk);
    bus.lut_number = 4'd5;
    bus.req_player = 1'b1;
    @(negedge clk);
    chk("t5_grant", bus.grant_player, 1);
    bus.req_player = 1'b0;
    @(negedge clk);
    chk("t5_in_wait", bus.busy, 1);
    bus.clr_round = 1'b1;
    @(negedge clk);
    bus.clr_round = 1'b0;
    chk("t5_busy", bus.busy, 0);
    chk("t5_hcnt", bus.house_cnt, 0);
    chk("t5_hpts", bus.house_pts, 0);
    chk("t5_hfive", bus.house_five, 0);
    cnt_v = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.card_valid) cnt_v++;
    end
    chk("t5_no_cv", cnt_v, 0);
    chk("t5_pcnt", bus.player_cnt, 0);
    do_draw(1'b0, 4'd4);
    chk("t5_after_pts", bus.player_pts, 8);
    chk("t5_after_cnt", bus.player_cnt, 1);

    // 6: rank 0 counts a card worth nothing and flags rank_err
    do_draw(1'b0, 4'd0);
    chk("t6_rerr", bus.rank_err, 1);
    chk("t6_cnt", bus.player_cnt, 2);
    chk("t6_pts", bus.player_pts, 8);

    // 6b: reset mid-WAIT clears every output immediately
    @(negedge clk);
    bus.lut_number = 4'd9;
    bus.req_player = 1'b1;
    @(negedge clk);
    bus.req_player = 1'b0;
    @(negedge clk);
    chk("t6_pre_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_pip", bus.lut_pip, 0);
    chk("t6_rst_cnt", bus.player_cnt, 0);
    chk("t6_rst_pts", bus.player_pts, 0);
    chk("t6_rst_rerr", bus.rank_err, 0);
    chk("t6_rst_num", bus.card_num, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_v = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.card_valid) cnt_v++;
    end
    chk("t6_no_cv", cnt_v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
